// File: rtl/ms_timekeeper.sv
// Time-of-day keeper (hh:mm:ss, packed BCD) advanced by an asynchronous 1 kHz
// reference, with a load port and a reference-rate monitor.
module ms_timekeeper #(
  parameter int unsigned MS_PER_SEC = 1000,
  parameter int unsigned MIN_GAP    = 40000,
  parameter int unsigned MAX_GAP    = 60000
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       clk_1kHz,
  input  logic       run,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       set_err,
  output logic       rate_err
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    LOCKED     = 2'd1,
    FAULT      = 2'd2
  } mon_state_e;

  localparam logic [9:0]  MS_LAST   = 10'(MS_PER_SEC - 1);
  localparam logic [16:0] MIN_GAP_W = 17'(MIN_GAP);
  localparam logic [16:0] MAX_GAP_W = 17'(MAX_GAP);

  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] tens_max);
    return (v[7:4] <= tens_max) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  // ---------------------------------------------------------------- edge detect
  logic       s1_q, s2_q, s3_q;
  logic [2:0] fill_q;
  logic       tick;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= '0;
    end else begin
      s1_q   <= clk_1kHz;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // s3 must hold a real input sample before an edge counts, so an input that
  // is already high when reset releases does not produce a phantom tick.
  assign tick = s2_q & ~s3_q & fill_q[2];

  // ---------------------------------------------------------------- timekeeping
  logic       load_ok, load;
  logic [9:0] ms_cnt_q, ms_cnt_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       set_err_q, set_err_d;

  assign load_ok = bcd_ok(set_hh, 4'd2) && bcd_ok(set_mm, 4'd5) &&
                   bcd_ok(set_ss, 4'd5) && (set_hh <= 8'h23);
  assign load    = set_en & load_ok;

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ms_cnt_d    = ms_cnt_q;
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    sec_pulse_d = 1'b0;
    set_err_d   = 1'b0;
    if (load) begin
      hh_d     = set_hh;
      mm_d     = set_mm;
      ss_d     = set_ss;
      ms_cnt_d = '0;
    end else begin
      set_err_d = set_en;
      if (tick && run) begin
        if (ms_cnt_q >= MS_LAST) begin
          ms_cnt_d    = '0;
          sec_pulse_d = 1'b1;
          if (ss_q == 8'h59) begin
            ss_d = 8'h00;
            if (mm_q == 8'h59) begin
              mm_d = 8'h00;
              hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
            end else begin
              mm_d = bcd_inc(mm_q);
            end
          end else begin
            ss_d = bcd_inc(ss_q);
          end
        end else begin
          ms_cnt_d = ms_cnt_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt_q    <= '0;
      hh_q        <= 8'h00;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      ms_cnt_q    <= ms_cnt_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      sec_pulse_q <= sec_pulse_d;
      set_err_q   <= set_err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign sec_pulse = sec_pulse_q;
  assign set_err   = set_err_q;

  // ---------------------------------------------------------------- rate monitor
  mon_state_e  state_q, state_d;
  logic [16:0] gap_q, gap_d, gap_inc;

  // gap_inc is the number of cycles since the last tick, counting this one.
  assign gap_inc = (&gap_q) ? gap_q : gap_q + 17'd1;
  assign gap_d   = tick ? '0 : gap_inc;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_FIRST;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_FIRST: if (tick) state_d = LOCKED;
      LOCKED:     if ((gap_inc > MAX_GAP_W) || (tick && (gap_inc < MIN_GAP_W)))
                    state_d = FAULT;
      FAULT:      if (load) state_d = WAIT_FIRST;
      default:    state_d = WAIT_FIRST;
    endcase
  end

  always_comb begin
    rate_err = (state_q == FAULT);
  end

endmodule
